// File: rtl/wavetable_reader.sv
// Wavetable sample reader: on each divided-clock tick, advances a phase accumulator,
// reads one signed sample from a synchronous ROM bank, scales it by volume and strobes it out.
module wavetable_reader #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int BANK_W  = 2,
  parameter int DATA_W  = 12
) (
  input  logic                      clock_in,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      sample_clk,
  input  logic [PHASE_W-1:0]        tuning_word,
  input  logic [BANK_W-1:0]         wave_sel,
  input  logic [7:0]                volume,
  output logic [BANK_W+ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         sample_out,
  output logic                      sample_valid,
  output logic                      phase_wrap,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    SCALE   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       sclk_q;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [BANK_W+ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                       wrap_pend_q, wrap_pend_d;
  logic [7:0]                 vol_q, vol_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic [DATA_W-1:0]          sample_out_q, sample_out_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       phase_wrap_q, phase_wrap_d;
  logic                       overrun_q, overrun_d;

  logic                       tick_s;
  logic [PHASE_W:0]           sum_s;
  logic signed [DATA_W+8:0]   prod_s;

  assign tick_s = sample_clk & ~sclk_q;
  assign sum_s  = {1'b0, phase_q} + {1'b0, tuning_word};
  assign prod_s = $signed(data_q) * $signed({1'b0, vol_q});

  // Next-state and datapath decode for the fetch/scale sequence
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    rom_addr_d     = rom_addr_q;
    wrap_pend_d    = wrap_pend_q;
    vol_d          = vol_q;
    data_d         = data_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    phase_wrap_d   = 1'b0;
    overrun_d      = overrun_q;

    // A tick that lands while a sample is in flight is lost, not queued
    if (tick_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (!enable) begin
          phase_d = '0;
        end else if (tick_s) begin
          rom_addr_d  = {wave_sel, phase_q[PHASE_W-1 -: ADDR_W]};
          phase_d     = sum_s[PHASE_W-1:0];
          wrap_pend_d = sum_s[PHASE_W];
          vol_d       = volume;
          state_d     = FETCH;
        end else begin
          phase_d = phase_q;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = rom_data;
        state_d = SCALE;
      end
      SCALE: begin
        sample_out_d   = prod_s[DATA_W+7:8];
        sample_valid_d = 1'b1;
        phase_wrap_d   = wrap_pend_q;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sclk_q         <= 1'b0;
      phase_q        <= '0;
      rom_addr_q     <= '0;
      wrap_pend_q    <= 1'b0;
      vol_q          <= 8'd0;
      data_q         <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      phase_wrap_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_q         <= sample_clk;
      phase_q        <= phase_d;
      rom_addr_q     <= rom_addr_d;
      wrap_pend_q    <= wrap_pend_d;
      vol_q          <= vol_d;
      data_q         <= data_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      phase_wrap_q   <= phase_wrap_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign phase_wrap   = phase_wrap_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: a behavioural phase/ROM/gain model predicts
// every address, sample, wrap flag and strobe timing for randomized and directed ticks.
module tb_wavetable_reader;

  logic        clock_in;
  logic        reset_n;
  logic        enable;
  logic        sample_clk;
  logic [23:0] tuning_word;
  logic [1:0]  wave_sel;
  logic [7:0]  volume;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        phase_wrap;
  logic        overrun;

  int          vectors;
  int          miscompares;
  logic [11:0] rom_mem [1024];
  logic [23:0] m_phase;

  wavetable_reader dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_clk  (sample_clk),
    .tuning_word (tuning_word),
    .wave_sel    (wave_sel),
    .volume      (volume),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .phase_wrap  (phase_wrap),
    .overrun     (overrun)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Synchronous ROM: one cycle from address to data
  always @(posedge clock_in) rom_data <= rom_mem[rom_addr];

  function automatic logic [11:0] scale_ref(input logic [11:0] d, input logic [7:0] v);
    int p;
    int q;
    p = int'($signed(d)) * int'(v);
    if (p >= 0) q = p / 256;
    else        q = -((-p + 255) / 256);
    return q[11:0];
  endfunction

  function automatic logic [9:0] model_addr();
    return {wave_sel, m_phase[23:16]};
  endfunction

  // One tick through the model and the DUT; optionally scramble inputs mid-flight
  task automatic do_tick(input bit scramble);
    logic [9:0]  ea;
    logic [24:0] sum;
    logic        ew;
    logic [11:0] eo;
    ea  = model_addr();
    sum = {1'b0, m_phase} + {1'b0, tuning_word};
    ew  = sum[24];
    m_phase = sum[23:0];
    eo  = scale_ref(rom_mem[ea], volume);
    sample_clk = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock_in);
      if (k == 1) begin
        vectors++;
        if (rom_addr !== ea) begin
          miscompares++;
          $display("FAIL rom_addr: got %h expected %h", rom_addr, ea);
        end
        sample_clk = 1'b0;
      end
      if (k == 2 && scramble) begin
        tuning_word = 24'($urandom);
        wave_sel    = 2'($urandom);
        volume      = 8'($urandom);
      end
      vectors++;
      if (sample_valid !== (k == 4)) begin
        miscompares++;
        $display("FAIL sample_valid cyc%0d: got %b expected %b", k, sample_valid, (k == 4));
      end
      vectors++;
      if (phase_wrap !== ((k == 4) && ew)) begin
        miscompares++;
        $display("FAIL phase_wrap cyc%0d: got %b expected %b", k, phase_wrap, ((k == 4) && ew));
      end
      if (k >= 4) begin
        vectors++;
        if (sample_out !== eo) begin
          miscompares++;
          $display("FAIL sample_out cyc%0d: got %h expected %h", k, sample_out, eo);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({rom_addr, sample_out, sample_valid, phase_wrap, overrun} !== 25'd0) begin
      miscompares++;
      $display("FAIL %s: got addr=%h out=%h v=%b w=%b ovr=%b expected all zero",
               tag, rom_addr, sample_out, sample_valid, phase_wrap, overrun);
    end
  endtask

  task automatic clear_phase();
    enable = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
    enable  = 1'b1;
    m_phase = 24'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock_in);
    check_outputs_zero("reset_state");
    reset_n = 1'b1;
    m_phase = 24'd0;
    @(negedge clock_in);
    check_outputs_zero("after_release");
  endtask

  task automatic test_first_samples();
    enable      = 1'b1;
    tuning_word = 24'h010000;
    wave_sel    = 2'd1;
    for (int i = 0; i < 3; i++) begin
      volume = 8'($urandom);
      do_tick(1'b0);
    end
  endtask

  task automatic test_phase_wrap();
    clear_phase();
    tuning_word = 24'h800000;
    wave_sel    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      volume = 8'($urandom);
      do_tick(1'b0);
    end
  endtask

  task automatic test_volume();
    logic [11:0] dv [4];
    logic [7:0]  vv [4];
    logic [11:0] ev [4];
    dv[0] = 12'h800; vv[0] = 8'd128; ev[0] = 12'hC00;
    dv[1] = 12'h005; vv[1] = 8'd255; ev[1] = 12'h004;
    dv[2] = 12'hFFF; vv[2] = 8'd1;   ev[2] = 12'hFFF;
    dv[3] = 12'h7FF; vv[3] = 8'd0;   ev[3] = 12'h000;
    tuning_word = 24'h013579;
    for (int i = 0; i < 4; i++) begin
      volume = vv[i];
      rom_mem[model_addr()] = dv[i];
      do_tick(1'b0);
      vectors++;
      if (sample_out !== ev[i]) begin
        miscompares++;
        $display("FAIL volume_case%0d: got %h expected %h", i, sample_out, ev[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    tuning_word = 24'h0A0000;
    do_tick(1'b0);
    enable = 1'b0;
    for (int t = 0; t < 3; t++) begin
      sample_clk = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock_in);
        sample_clk = 1'b0;
        vectors++;
        if (sample_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL gated_valid: got %b expected 0", sample_valid);
        end
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL gated_overrun: got %b expected 0", overrun);
    end
    enable  = 1'b1;
    m_phase = 24'd0;
    wave_sel = 2'd2;
    do_tick(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 12'($urandom);
    tuning_word = 24'($urandom);
    wave_sel    = 2'($urandom);
    volume      = 8'($urandom);
    for (int i = 0; i < 24; i++) do_tick(1'b1);
  endtask

  task automatic test_overrun();
    logic [9:0]  ea;
    logic [24:0] sum;
    int          nvalid;
    tuning_word = 24'h123456;
    volume      = 8'd200;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_pre: got %b expected 0", overrun);
    end
    ea  = model_addr();
    sum = {1'b0, m_phase} + {1'b0, tuning_word};
    m_phase = sum[23:0];
    nvalid  = 0;
    sample_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock_in);
      if (k == 1) begin
        vectors++;
        if (rom_addr !== ea) begin
          miscompares++;
          $display("FAIL overrun_addr: got %h expected %h", rom_addr, ea);
        end
      end
      sample_clk = (k == 2);
      if (sample_valid === 1'b1) nvalid++;
      if (k >= 3) begin
        vectors++;
        if (overrun !== 1'b1) begin
          miscompares++;
          $display("FAIL overrun_sticky cyc%0d: got %b expected 1", k, overrun);
        end
      end
    end
    vectors++;
    if (nvalid != 1) begin
      miscompares++;
      $display("FAIL overrun_valid_count: got %0d expected 1", nvalid);
    end
    do_tick(1'b0);
  endtask

  task automatic test_mid_reset();
    sample_clk = 1'b1;
    @(negedge clock_in);
    sample_clk = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset_async");
    @(negedge clock_in);
    reset_n = 1'b1;
    m_phase = 24'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock_in);
      vectors++;
      if (sample_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_valid: got %b expected 0", sample_valid);
      end
    end
    wave_sel = 2'd3;
    do_tick(1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    sample_clk  = 1'b0;
    tuning_word = 24'd0;
    wave_sel    = 2'd0;
    volume      = 8'd0;
    m_phase     = 24'd0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 12'($urandom);
    @(negedge clock_in);
    test_reset();
    test_first_samples();
    test_phase_wrap();
    test_volume();
    test_enable_gating();
    test_random();
    test_overrun();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
